sum_result_fifo: RTL and testbench

- Downstream consumer of the pipelined m-word adder.
- Captures each finished result (sum plus carry) on the rising edge of the adder's end flag.
- Optionally derives the mean of the m words.
- Buffers results in a small FIFO and hands them to the next stage over a valid/ready handshake.

---
 rtl/sum_result_fifo_if.sv | 20 ++
 rtl/sum_result_fifo.sv | 118 +++++++++++
 tb/tb_sum_result_fifo.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sum_result_fifo_if.sv
// Result handshake between sum_result_fifo and the next stage.
// The mean field exists only when SUM_MEAN_EN is defined.
interface sum_result_fifo_if #(
  parameter int unsigned n = 32
);
  logic         valid;
  logic         ready;
  logic [n:0]   res;
`ifdef SUM_MEAN_EN
  logic [n-1:0] mean;
`endif

`ifdef SUM_MEAN_EN
  modport master (output valid, output res, output mean, input ready);
  modport slave  (input valid, input res, input mean, output ready);
`else
  modport master (output valid, output res, input ready);
  modport slave  (input valid, input res, output ready);
`endif
endinterface

// File: rtl/sum_result_fifo.sv
// Captures adder results on the rising edge of fl_end_i into a first-word-fall-through FIFO.
// Optional mean storage and output are enabled by defining SUM_MEAN_EN.
module sum_result_fifo #(
  parameter int unsigned n     = 32,
  parameter int unsigned m     = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [n-1:0]                 sum_i,
  input  logic                         c_i,
  input  logic                         fl_end_i,
  sum_result_fifo_if.master            deq,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         ovf_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = $clog2(DEPTH + 1);
  localparam int unsigned MShift = $clog2(m);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic            fl_d_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            valid_q, full_q, ovf_q;
  logic [n:0]      res_q, res_d, new_res;
  logic [n:0]      res_mem_q [DEPTH];
  logic            cap, pop, push_acc, drop, bypass;

`ifdef SUM_MEAN_EN
  logic [n-1:0] mean_q, mean_d, new_mean;
  logic [n-1:0] mean_mem_q [DEPTH];
`endif

  always_comb begin
    cap      = fl_end_i & ~fl_d_q;
    pop      = valid_q & deq.ready;
    push_acc = cap & ((count_q < DepthCnt) | pop);
    drop     = cap & ~push_acc;
    new_res  = {c_i, sum_i};
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_acc && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push_acc) begin
      count_d = count_q - CntW'(1);
    end

    // The incoming word becomes the head when it lands where the read pointer will point.
    bypass = push_acc & (wr_ptr_q == rd_ptr_d);
    res_d  = bypass ? new_res : res_mem_q[rd_ptr_d];
  end

`ifdef SUM_MEAN_EN
  always_comb begin
    new_mean = n'(new_res >> MShift);
    mean_d   = bypass ? new_mean : mean_mem_q[rd_ptr_d];
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fl_d_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        res_mem_q[i] <= '0;
      end
    end else begin
      fl_d_q   <= fl_end_i;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= (count_d != '0);
      full_q   <= (count_d == DepthCnt);
      res_q    <= res_d;
      if (drop) begin
        ovf_q <= 1'b1;
      end
      if (push_acc) begin
        res_mem_q[wr_ptr_q] <= new_res;
        wr_ptr_q            <= wr_ptr_q + PtrW'(1);
      end
    end
  end

`ifdef SUM_MEAN_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mean_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mean_mem_q[i] <= '0;
      end
    end else begin
      mean_q <= mean_d;
      if (push_acc) begin
        mean_mem_q[wr_ptr_q] <= new_mean;
      end
    end
  end

  assign deq.mean = mean_q;
`endif

  assign deq.valid = valid_q;
  assign deq.res   = res_q;
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_sum_result_fifo.sv
// Directed bench for sum_result_fifo (n=32, m=4, DEPTH=4); mean checks only with SUM_MEAN_EN.
module tb_sum_result_fifo;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] sum_i;
  logic        c_i;
  logic        fl_end_i;
  logic [2:0]  count_o;
  logic        full_o;
  logic        ovf_o;

  int tests_run    = 0;
  int tests_failed = 0;

  sum_result_fifo_if #(.n(32)) bus ();

  sum_result_fifo #(.n(32), .m(4), .DEPTH(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .sum_i    (sum_i),
    .c_i      (c_i),
    .fl_end_i (fl_end_i),
    .deq      (bus),
    .count_o  (count_o),
    .full_o   (full_o),
    .ovf_o    (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drop fl_end_i for one cycle, then raise it with the given result.
  task automatic push_val(input logic [31:0] val, input logic carry);
    fl_end_i = 1'b0;
    tick();
    sum_i    = val;
    c_i      = carry;
    fl_end_i = 1'b1;
    tick();
  endtask

  initial begin
    rst_i    = 1'b0;
    sum_i    = '0;
    c_i      = 1'b0;
    fl_end_i = 1'b1;
    bus.ready = 1'b0;

    // Reset with fl_end_i high
    repeat (3) tick();
    check("rst_valid", 64'(bus.valid), 64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_ovf", 64'(ovf_o), 64'd0);
    check("rst_res", 64'(bus.res), 64'd0);
    rst_i = 1'b1;
    repeat (3) tick();
    check("rel_no_cap", 64'(count_o), 64'd0);
    check("rel_no_valid", 64'(bus.valid), 64'd0);

    // Single result
    push_val(32'h0000_0010, 1'b0);
    check("single_valid", 64'(bus.valid), 64'd1);
    check("single_res", 64'(bus.res), 64'h0_0000_0010);
    check("single_count", 64'(count_o), 64'd1);
`ifdef SUM_MEAN_EN
    check("single_mean", 64'(bus.mean), 64'h0000_0004);
`endif
    tick();
    check("stall_res", 64'(bus.res), 64'h0_0000_0010);
    check("stall_valid", 64'(bus.valid), 64'd1);
    bus.ready = 1'b1;
    tick();
    check("pop_valid", 64'(bus.valid), 64'd0);
    check("pop_count", 64'(count_o), 64'd0);
    bus.ready = 1'b0;

    // Carry included in result and mean
    push_val(32'hFFFF_FFFC, 1'b1);
    check("carry_res", 64'(bus.res), 64'h1_FFFF_FFFC);
`ifdef SUM_MEAN_EN
    check("carry_mean", 64'(bus.mean), 64'h7FFF_FFFF);
`endif
    bus.ready = 1'b1;
    tick();
    check("carry_pop", 64'(count_o), 64'd0);
    // Ready on an empty FIFO must not underflow
    tick();
    tick();
    check("empty_count", 64'(count_o), 64'd0);
    check("empty_valid", 64'(bus.valid), 64'd0);
    bus.ready = 1'b0;

    // Overflow: five captures, fifth dropped
    for (int i = 1; i <= 4; i++) begin
      push_val(32'(i), 1'b0);
    end
    check("fill_count", 64'(count_o), 64'd4);
    check("fill_full", 64'(full_o), 64'd1);
    check("fill_ovf", 64'(ovf_o), 64'd0);
    push_val(32'd5, 1'b0);
    check("ovf_count", 64'(count_o), 64'd4);
    check("ovf_full", 64'(full_o), 64'd1);
    check("ovf_flag", 64'(ovf_o), 64'd1);
    check("drain_res1", 64'(bus.res), 64'd1);
    bus.ready = 1'b1;
    tick();
    check("drain_res2", 64'(bus.res), 64'd2);
    check("drain_notfull", 64'(full_o), 64'd0);
    tick();
    check("drain_res3", 64'(bus.res), 64'd3);
    tick();
    check("drain_res4", 64'(bus.res), 64'd4);
    tick();
    check("drain_empty", 64'(bus.valid), 64'd0);
    check("ovf_sticky", 64'(ovf_o), 64'd1);
    bus.ready = 1'b0;

    // Asynchronous reset clears the sticky flag
    fl_end_i = 1'b0;
    rst_i = 1'b0;
    #1;
    check("areset_ovf", 64'(ovf_o), 64'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // Simultaneous push and pop while full
    for (int i = 1; i <= 4; i++) begin
      push_val(32'hA0 + 32'(i), 1'b0);
    end
    check("sim_full", 64'(full_o), 64'd1);
    check("sim_head", 64'(bus.res), 64'hA1);
    fl_end_i = 1'b0;
    tick();
    sum_i     = 32'hA5;
    fl_end_i  = 1'b1;
    bus.ready = 1'b1;
    tick();
    check("sim_count", 64'(count_o), 64'd4);
    check("sim_ovf", 64'(ovf_o), 64'd0);
    check("sim_res2", 64'(bus.res), 64'hA2);
    tick();
    check("sim_res3", 64'(bus.res), 64'hA3);
    tick();
    check("sim_res4", 64'(bus.res), 64'hA4);
    tick();
    check("sim_res5", 64'(bus.res), 64'hA5);
    tick();
    check("sim_empty", 64'(bus.valid), 64'd0);
    bus.ready = 1'b0;

    // Level held high for ten cycles yields one entry
    fl_end_i = 1'b0;
    tick();
    sum_i    = 32'h77;
    fl_end_i = 1'b1;
    repeat (10) tick();
    check("level_count", 64'(count_o), 64'd1);
    check("level_res", 64'(bus.res), 64'h77);

    // Asynchronous reset discards held entries
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.valid), 64'd0);
    check("mid_rst_count", 64'(count_o), 64'd0);
    tick();
    rst_i = 1'b1;
    repeat (2) tick();
    check("mid_rel_no_cap", 64'(count_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
